// File: rtl/morse_symbol_decoder.sv
// Morse key decoder: measures press/gap lengths in time-base ticks, classifies
// dots and dashes, and emits one ASCII byte per letter plus a space per word gap.
module morse_symbol_decoder #(
   parameter int unsigned DASH_TICKS       = 3,
   parameter int unsigned LETTER_GAP_TICKS = 3,
   parameter int unsigned WORD_GAP_TICKS   = 7,
   parameter int unsigned CNT_W            = 4
) (
   input  logic       in_clk,
   input  logic       rst,
   input  logic       time_base,
   input  logic       key_in,
   output logic [7:0] char_data,
   output logic       char_valid,
   output logic       sym_valid,
   output logic       sym_dash,
   output logic       busy
);

   localparam int unsigned PAT_W = 5;
   localparam int unsigned SC_W  = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_e;

   state_e             state_q, state_d;
   logic               key_meta_q, key_s_q, tb_d_q;
   logic [CNT_W-1:0]   press_q, press_d, gap_q, gap_d;
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic [SC_W-1:0]    count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [7:0]         char_data_q, char_data_d;
   logic               char_valid_q, char_valid_d;
   logic               sym_valid_q, sym_valid_d;
   logic               sym_dash_q, sym_dash_d;
   logic               busy_q, busy_d;
   logic               tick, is_dash;
   logic [CNT_W-1:0]   press_inc, gap_inc;

   // Pattern is right-aligned: the most recent symbol is the LSB, 1 = dash.
   function automatic logic [7:0] decode(input logic [SC_W-1:0] len,
                                         input logic [PAT_W-1:0] pat);
      logic [7:0] c;
      case ({len, pat})
         {3'd1, 5'b00000}: c = "E";  {3'd1, 5'b00001}: c = "T";
         {3'd2, 5'b00000}: c = "I";  {3'd2, 5'b00001}: c = "A";
         {3'd2, 5'b00010}: c = "N";  {3'd2, 5'b00011}: c = "M";
         {3'd3, 5'b00000}: c = "S";  {3'd3, 5'b00001}: c = "U";
         {3'd3, 5'b00010}: c = "R";  {3'd3, 5'b00011}: c = "W";
         {3'd3, 5'b00100}: c = "D";  {3'd3, 5'b00101}: c = "K";
         {3'd3, 5'b00110}: c = "G";  {3'd3, 5'b00111}: c = "O";
         {3'd4, 5'b00000}: c = "H";  {3'd4, 5'b00001}: c = "V";
         {3'd4, 5'b00010}: c = "F";  {3'd4, 5'b00100}: c = "L";
         {3'd4, 5'b00110}: c = "P";  {3'd4, 5'b00111}: c = "J";
         {3'd4, 5'b01000}: c = "B";  {3'd4, 5'b01001}: c = "X";
         {3'd4, 5'b01010}: c = "C";  {3'd4, 5'b01011}: c = "Y";
         {3'd4, 5'b01100}: c = "Z";  {3'd4, 5'b01101}: c = "Q";
         {3'd5, 5'b01111}: c = "1";  {3'd5, 5'b00111}: c = "2";
         {3'd5, 5'b00011}: c = "3";  {3'd5, 5'b00001}: c = "4";
         {3'd5, 5'b00000}: c = "5";  {3'd5, 5'b10000}: c = "6";
         {3'd5, 5'b11000}: c = "7";  {3'd5, 5'b11100}: c = "8";
         {3'd5, 5'b11110}: c = "9";  {3'd5, 5'b11111}: c = "0";
         default:          c = "?";
      endcase
      return c;
   endfunction

   assign tick      = time_base & ~tb_d_q;
   assign is_dash   = (press_q >= CNT_W'(DASH_TICKS));
   assign press_inc = (press_q == CNT_MAX) ? press_q : press_q + CNT_W'(1);
   assign gap_inc   = (gap_q == CNT_MAX) ? gap_q : gap_q + CNT_W'(1);

   always_ff @(posedge in_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         key_meta_q   <= 1'b0;
         key_s_q      <= 1'b0;
         tb_d_q       <= 1'b0;
         press_q      <= '0;
         gap_q        <= '0;
         pattern_q    <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         char_data_q  <= 8'h00;
         char_valid_q <= 1'b0;
         sym_valid_q  <= 1'b0;
         sym_dash_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_meta_q   <= key_in;
         key_s_q      <= key_meta_q;
         tb_d_q       <= time_base;
         press_q      <= press_d;
         gap_q        <= gap_d;
         pattern_q    <= pattern_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         char_data_q  <= char_data_d;
         char_valid_q <= char_valid_d;
         sym_valid_q  <= sym_valid_d;
         sym_dash_q   <= sym_dash_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and output logic; everything advances only on tick cycles.
   always_comb begin
      state_d      = state_q;
      press_d      = press_q;
      gap_d        = gap_q;
      pattern_d    = pattern_q;
      count_d      = count_q;
      ovf_d        = ovf_q;
      char_data_d  = char_data_q;
      char_valid_d = 1'b0;
      sym_valid_d  = 1'b0;
      sym_dash_d   = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (key_s_q) begin
                  press_d = CNT_W'(1);
                  state_d = ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (key_s_q) begin
                  press_d = press_inc;
               end else begin
                  sym_valid_d = 1'b1;
                  sym_dash_d  = is_dash;
                  if (count_q < SC_W'(5)) begin
                     pattern_d = {pattern_q[PAT_W-2:0], is_dash};
                     count_d   = count_q + SC_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
                  gap_d   = CNT_W'(1);
                  state_d = ST_GAP;
               end
            end
            ST_GAP: begin
               if (key_s_q) begin
                  press_d = CNT_W'(1);
                  state_d = ST_PRESS;
               end else begin
                  gap_d = gap_inc;
                  if (gap_inc == CNT_W'(LETTER_GAP_TICKS) && count_q != '0) begin
                     char_valid_d = 1'b1;
                     char_data_d  = ovf_q ? 8'h3F : decode(count_q, pattern_q);
                     pattern_d    = '0;
                     count_d      = '0;
                     ovf_d        = 1'b0;
                  end
                  if (gap_inc == CNT_W'(WORD_GAP_TICKS)) begin
                     char_valid_d = 1'b1;
                     char_data_d  = 8'h20;
                     gap_d        = '0;
                     state_d      = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   assign char_data  = char_data_q;
   assign char_valid = char_valid_q;
   assign sym_valid  = sym_valid_q;
   assign sym_dash   = sym_dash_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Scoreboard bench for morse_symbol_decoder: stimulus queues expected strobes
// and status checks; a single monitor process compares and keeps the counts.
module tb_morse_symbol_decoder;

   typedef struct {
      logic [7:0] data;
      int         tick;
   } exp_t;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] val;
   } chk_t;

   logic       in_clk = 1'b0;
   logic       rst = 1'b1;
   logic       time_base = 1'b0;
   logic       key_in = 1'b1;
   logic [7:0] char_data;
   logic       char_valid, sym_valid, sym_dash, busy;

   exp_t char_q[$];
   exp_t sym_q[$];
   chk_t chk_q[$];
   int   tick_no = 0;
   time  rise_time = 0;
   bit   done = 1'b0;
   int   vectors = 0;
   int   errors = 0;

   morse_symbol_decoder dut (
      .in_clk     (in_clk),
      .rst        (rst),
      .time_base  (time_base),
      .key_in     (key_in),
      .char_data  (char_data),
      .char_valid (char_valid),
      .sym_valid  (sym_valid),
      .sym_dash   (sym_dash),
      .busy       (busy)
   );

   always #5 in_clk = ~in_clk;

   // One time-base period with key_in held (or glitched between ticks).
   task automatic step(input logic k, input bit glitch = 1'b0);
      key_in = k;
      if (glitch) begin
         @(negedge in_clk); key_in = 1'b1;
         repeat (2) @(negedge in_clk); key_in = 1'b0;
      end
      repeat (4) @(negedge in_clk);
      time_base = 1'b1;
      tick_no++;
      rise_time = $time;
      repeat (4) @(negedge in_clk);
      time_base = 1'b0;
   endtask

   task automatic sym(input int len, input logic dash);
      exp_t e;
      for (int i = 0; i < len; i++) step(1'b1);
      e.data = {7'd0, dash};
      e.tick = tick_no + 1;
      sym_q.push_back(e);
      step(1'b0);
   endtask

   task automatic letter_end(input logic [7:0] c);
      exp_t e;
      step(1'b0);
      e.data = c;
      e.tick = tick_no + 1;
      char_q.push_back(e);
      step(1'b0);
   endtask

   task automatic word_end();
      exp_t e;
      repeat (3) step(1'b0);
      e.data = 8'h20;
      e.tick = tick_no + 1;
      char_q.push_back(e);
      step(1'b0);
   endtask

   task automatic chk(input string name, input int sel, input logic [7:0] val);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.val  = val;
      chk_q.push_back(c);
      repeat (2) @(negedge in_clk);
   endtask

   // Stimulus
   initial begin
      @(negedge in_clk); time_base = 1'b1;
      @(negedge in_clk); time_base = 1'b0;
      chk("rst_char_data", 0, 8'h00);
      chk("rst_char_valid", 1, 8'h00);
      chk("rst_sym_valid", 2, 8'h00);
      chk("rst_sym_dash", 3, 8'h00);
      chk("rst_busy", 4, 8'h00);
      rst = 1'b0;
      key_in = 1'b0;
      repeat (10) step(1'b0);

      // A = .-
      sym(1, 1'b0);
      chk("busy_mid_letter", 4, 8'h01);
      sym(3, 1'b1);
      letter_end("A");
      word_end();
      chk("hold_space", 0, 8'h20);

      // E then word gap
      sym(1, 1'b0);
      letter_end("E");
      word_end();
      chk("busy_after_word", 4, 8'h00);

      // six dots overflow
      repeat (6) sym(1, 1'b0);
      letter_end(8'h3F);
      word_end();

      // ..-- unmatched
      sym(1, 1'b0); sym(1, 1'b0); sym(3, 1'b1); sym(3, 1'b1);
      letter_end(8'h3F);
      word_end();

      // glitches between ticks are ignored
      repeat (3) step(1'b0, 1'b1);
      chk("glitch_busy", 4, 8'h00);

      // 20-tick hold saturates press counter
      sym(20, 1'b1);
      letter_end("T");
      word_end();

      // a few table entries: S, 5, 0, Q
      repeat (3) sym(1, 1'b0);
      letter_end("S");
      repeat (5) sym(1, 1'b0);
      letter_end("5");
      repeat (5) sym(3, 1'b1);
      letter_end("0");
      sym(3, 1'b1); sym(3, 1'b1); sym(1, 1'b0); sym(3, 1'b1);
      letter_end("Q");
      word_end();

      // reset mid-letter discards the partial letter
      sym(1, 1'b0); sym(1, 1'b0);
      @(negedge in_clk); rst = 1'b1;
      @(negedge in_clk); rst = 1'b0;
      chk("rst_mid_busy", 4, 8'h00);
      sym(3, 1'b1);
      letter_end("T");
      word_end();
      chk("final_char_data", 0, 8'h20);

      repeat (4) @(negedge in_clk);
      done = 1'b1;
   end

   // Monitor: the only process that compares and counts.
   initial begin
      logic prev_cv = 1'b0;
      logic prev_sv = 1'b0;
      forever begin
         @(negedge in_clk);
         while (chk_q.size() > 0) begin
            chk_t c;
            logic [7:0] act;
            c = chk_q.pop_front();
            case (c.sel)
               0: act = char_data;
               1: act = {7'd0, char_valid};
               2: act = {7'd0, sym_valid};
               3: act = {7'd0, sym_dash};
               default: act = {7'd0, busy};
            endcase
            vectors++;
            if (act !== c.val) begin
               errors++;
               $display("FAIL %s: got %h, expected %h", c.name, act, c.val);
            end
         end
         if (char_valid) begin
            vectors++;
            if (char_q.size() == 0) begin
               errors++;
               $display("FAIL char_unexpected: got %h at tick %0d, expected no strobe",
                        char_data, tick_no);
            end else begin
               exp_t e;
               e = char_q.pop_front();
               if (char_data !== e.data || tick_no != e.tick || ($time - rise_time) != 10) begin
                  errors++;
                  $display("FAIL char: got %h tick %0d dt %0t, expected %h tick %0d dt 10",
                           char_data, tick_no, $time - rise_time, e.data, e.tick);
               end
            end
            if (prev_cv) begin
               errors++;
               $display("FAIL char_width: got 2-cycle strobe, expected 1 cycle");
            end
         end
         if (sym_valid) begin
            vectors++;
            if (sym_q.size() == 0) begin
               errors++;
               $display("FAIL sym_unexpected: got dash=%b at tick %0d, expected no strobe",
                        sym_dash, tick_no);
            end else begin
               exp_t e;
               e = sym_q.pop_front();
               if (sym_dash !== e.data[0] || tick_no != e.tick || ($time - rise_time) != 10) begin
                  errors++;
                  $display("FAIL sym: got dash=%b tick %0d dt %0t, expected dash=%b tick %0d dt 10",
                           sym_dash, tick_no, $time - rise_time, e.data[0], e.tick);
               end
            end
            if (prev_sv) begin
               errors++;
               $display("FAIL sym_width: got 2-cycle strobe, expected 1 cycle");
            end
         end
         prev_cv = char_valid;
         prev_sv = sym_valid;
         if (done) begin
            vectors++;
            if (char_q.size() != 0 || sym_q.size() != 0) begin
               errors++;
               $display("FAIL missing_strobes: got %0d chars %0d syms pending, expected 0",
                        char_q.size(), sym_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: got no end of run, expected finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
